inst_enc_loader: RTL
====================

# inst_enc_loader

Sequential RV32I instruction encoder and instruction-RAM loader, the write-side counterpart of the core's instruction decoder. It accepts symbolic instruction records over a valid/ready stream from the debug/boot host and encodes each into a 32-bit word for the core's supported subset. It writes the words to consecutive instruction-RAM addresses, then reports completion or the first error. It sits between the host bridge and the IRAM write port and runs while the core is held in reset.

## Interface
- ADDR_W, 10, IRAM word-address width
- BASE_ADDR, 0, first word address written after start
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears counters/error, enters LOAD
- req_valid  in  1  record valid
- req_ready  out  1  record accepted when valid&ready at rising edge
- req_op  in  5  op enum from package (OP_ADD..OP_JAL, 24 codes)
- req_rd / req_rs1 / req_rs2  in  5 each  register indices
- req_imm  in  32  signed byte offset / immediate; LUI uses bits 19:0 as upper immediate
- req_last  in  1  final record of program
- iram_we  out  1  write strobe, one cycle per word
- iram_addr  out  ADDR_W  word address
- iram_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD or DRAIN
- done  out  1  state is DONE
- err_code  out  2  0 none, 1 illegal op, 2 imm out of range, 3 IRAM overflow
- count  out  ADDR_W+1  words written since start

## Operation
- FSM: IDLE -> (start) LOAD -> (last accepted or error) DRAIN -> DONE -> (start) LOAD.
- req_ready = 1 only in LOAD and not in a start cycle.
- Encoding: R = funct7|rs2|rs1|funct3|rd|opcode; I = imm[11:0]; shifts use funct7|imm[4:0]; S splits imm[11:5]/[4:0]; B packs imm[12|10:5|4:1|11]; J packs imm[20|10:1|11|19:12]; LUI = imm[19:0]<<12. Opcodes and funct fields must match the decoder bit-for-bit.
- Accepted record with op >= 24: not written; err_code=1; go to DRAIN.
- Word address reaches 2^ADDR_W-1 with record written and req_last=0: err_code=3; go to DRAIN.
- First error is sticky until start or rst.
- start while LOAD/DRAIN: restart. A write already registered still completes; the address restarts at BASE_ADDR the next cycle.

## Timing
- Record accepted at edge N -> iram_we, iram_addr and iram_wdata valid throughout cycle N+1. count increments at edge N+1.
- Back-to-back acceptance at full rate: one word per cycle, no bubbles.
- After req_last is accepted at edge N, state is DRAIN in N+1 and done=1 from N+2.
- Reset values: iram_we=0, iram_addr=0, iram_wdata=0, req_ready=0, busy=0, done=0, err_code=0, count=0, state IDLE.
- rst mid-load drops iram_we immediately (asynchronous) and discards the in-flight word.

## Configuration
- INST_ENC_RANGE_CHECK_EN defined:
  - I/S imm must lie in [-2048,2047].
  - B imm must be in [-4096,4094] and even; J imm in [-2^20,2^20-2] and even.
  - shamt must be in 0..31; LUI imm in [0,2^20-1].
  - Violation -> err_code=2, word not written, DRAIN.
- Undefined: fields are silently truncated, bit 0 of B/J offsets is dropped, and err_code=2 never occurs.

## Structure
- Shared package holds:
  - op enum;
  - OPC_* opcode, FUNCT3_* and FUNCT7_* constants, shared with the decoder;
  - ERR_* codes.
- One combinational sub-module, inst_enc_word: (op, rd, rs1, rs2, imm) -> (word, illegal, range_err). The loader adds the FSM, address counter and output register.

## Test plan
- start; addi x1,x0,5; last -> single write, addr 0 data 0x00500093; done=1 two cycles after acceptance.
- add x3,x1,x2; sw x2,8(x1); srai x4,x1,3 back-to-back -> 0x002081B3, 0x0020A423, 0x4030D213 at addrs 0,1,2 on consecutive cycles; count=3.
- beq x1,x2,-4; jal x1,8; lui x5,0x12345 -> 0xFE208EE3, 0x008000EF, 0x123452B7.
- op=25 as second record -> one write only; err_code=1; done=1; next start clears err_code.
- With ADDR_W=2, five records without last -> writes at addrs 0..3; err_code=3 after the fourth write; fifth record not accepted.
- addi with imm=4096 -> macro on: no write, err_code=2; macro off: 0x00000093 written. Also assert rst mid-stream -> iram_we=0 the same cycle and all outputs at reset values.

Source files
------------

// File: rtl/inst_enc_loader_pkg.sv
// rtl/inst_enc_loader_pkg.sv - shared op enum, RV32I opcode/funct constants and error codes
// Opcode and funct values are shared with the core's instruction decoder.
package inst_enc_loader_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_JAL
  } op_e;

  localparam int unsigned NUM_OPS = 24;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SR      = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_LW      = 3'b010;
  localparam logic [2:0] FUNCT3_SW      = 3'b010;
  localparam logic [2:0] FUNCT3_BEQ     = 3'b000;
  localparam logic [2:0] FUNCT3_BNE     = 3'b001;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U} fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

  // True when v, read as signed, is representable in n bits two's complement.
  function automatic logic fits_s(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = $signed(v) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/inst_enc_loader_if.sv
// rtl/inst_enc_loader_if.sv - host record stream plus IRAM write port
interface inst_enc_loader_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              req_last;
  logic              iram_we;
  logic [ADDR_W-1:0] iram_addr;
  logic [31:0]       iram_wdata;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last,
    input  req_ready, iram_we, iram_addr, iram_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, req_last,
    output req_ready, iram_we, iram_addr, iram_wdata
  );
endinterface

// File: rtl/inst_enc_loader_word.sv
// rtl/inst_enc_loader_word.sv - combinational RV32I encoder (inst_enc_word)
// INST_ENC_RANGE_CHECK_EN enables immediate range checking; otherwise fields are truncated.
module inst_enc_word
  import inst_enc_loader_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);
  fmt_e       fmt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    fmt     = FMT_R;
    opc     = OPC_OP;
    f3      = FUNCT3_ADD_SUB;
    f7      = FUNCT7_BASE;
    illegal = 1'b0;
    case (op)
      OP_ADD:  f3 = FUNCT3_ADD_SUB;
      OP_SUB:  begin f3 = FUNCT3_ADD_SUB; f7 = FUNCT7_ALT; end
      OP_SLL:  f3 = FUNCT3_SLL;
      OP_SLT:  f3 = FUNCT3_SLT;
      OP_SLTU: f3 = FUNCT3_SLTU;
      OP_XOR:  f3 = FUNCT3_XOR;
      OP_SRL:  f3 = FUNCT3_SR;
      OP_SRA:  begin f3 = FUNCT3_SR; f7 = FUNCT7_ALT; end
      OP_OR:   f3 = FUNCT3_OR;
      OP_AND:  f3 = FUNCT3_AND;
      OP_ADDI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = FUNCT3_ADD_SUB; end
      OP_SLTI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = FUNCT3_SLT; end
      OP_XORI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = FUNCT3_XOR; end
      OP_ORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = FUNCT3_OR; end
      OP_ANDI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = FUNCT3_AND; end
      OP_SLLI: begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = FUNCT3_SLL; end
      OP_SRLI: begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = FUNCT3_SR; end
      OP_SRAI: begin fmt = FMT_SH; opc = OPC_OP_IMM; f3 = FUNCT3_SR; f7 = FUNCT7_ALT; end
      OP_LW:   begin fmt = FMT_I; opc = OPC_LOAD; f3 = FUNCT3_LW; end
      OP_SW:   begin fmt = FMT_S; opc = OPC_STORE; f3 = FUNCT3_SW; end
      OP_BEQ:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = FUNCT3_BEQ; end
      OP_BNE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = FUNCT3_BNE; end
      OP_LUI:  begin fmt = FMT_U; opc = OPC_LUI; end
      OP_JAL:  begin fmt = FMT_J; opc = OPC_JAL; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I:   word = {imm[11:0], rs1, f3, rd, opc};
      FMT_SH:  word = {f7, imm[4:0], rs1, f3, rd, opc};
      FMT_S:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: word = {imm[19:0], rd, opc};
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = !fits_s(imm, 12);
      FMT_SH:       range_err = (imm[31:5] != '0);
      FMT_B:        range_err = !fits_s(imm, 13) || imm[0];
      FMT_J:        range_err = !fits_s(imm, 21) || imm[0];
      FMT_U:        range_err = (imm[31:20] != '0);
      default:      range_err = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign range_err     = 1'b0;
`endif

endmodule

// File: rtl/inst_enc_loader.sv
// rtl/inst_enc_loader.sv - record-to-IRAM loader: FSM, word address counter, write register
// Range checking in the encoder is controlled by INST_ENC_RANGE_CHECK_EN.
module inst_enc_loader
  import inst_enc_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  inst_enc_loader_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_range_err;
  logic        accept;

  inst_enc_word u_word (
    .op        (bus.req_op),
    .rd        (bus.req_rd),
    .rs1       (bus.req_rs1),
    .rs2       (bus.req_rs2),
    .imm       (bus.req_imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range_err)
  );

  assign bus.req_ready = (state_q == ST_LOAD) && !start;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    count_d = count_q + (ADDR_W+1)'(we_q);
    // A write registered before start still drives the IRAM this cycle.
    if (start) begin
      state_d = ST_LOAD;
      ptr_d   = ADDR_W'(BASE_ADDR);
      err_d   = ERR_NONE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (enc_illegal) begin
              err_d   = ERR_ILLEGAL;
              state_d = ST_DRAIN;
            end else if (enc_range_err) begin
              err_d   = ERR_RANGE;
              state_d = ST_DRAIN;
            end else begin
              we_d    = 1'b1;
              addr_d  = ptr_q;
              wdata_d = enc_word;
              if (bus.req_last) begin
                state_d = ST_DRAIN;
              end else if (&ptr_q) begin
                err_d   = ERR_OVERFLOW;
                state_d = ST_DRAIN;
              end else begin
                ptr_d = ptr_q + ADDR_W'(1);
              end
            end
          end
        end
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= ADDR_W'(BASE_ADDR);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= ERR_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign bus.iram_we    = we_q;
  assign bus.iram_addr  = addr_q;
  assign bus.iram_wdata = wdata_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done           = (state_q == ST_DONE);
  assign err_code       = err_q;
  assign count          = count_q;

endmodule
